pipeline_hazard_controller: RTL



---
 rtl/hazard_pkg.sv | 36 +++
 rtl/forwarding_unit.sv | 20 ++
 rtl/pipeline_hazard_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the RV32 pipeline hazard controller.
// Provides forwarding select encoding, the load result-source code, the MDU
// hold FSM state encoding and the per-operand forwarding priority function.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } forward_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Width of the multiply hold counter (MUL_CYCLES is limited to 1..15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_WAIT = 2'b01,
    DIV_WAIT = 2'b10
  } mdu_state_t;

  // Memory stage is younger than Writeback, so it wins; x0 never forwards.
  function automatic forward_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m == rs) && (rs != 5'd0)) return FWD_MEM;
    else if (wr_w && (rd_w == rs) && (rs != 5'd0)) return FWD_WB;
    else return FWD_RF;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: combinational operand bypass select for both Execute sources.
// Ports: rs1_e_i/rs2_e_i Execute sources; rd_m_i/reg_write_m_i and
// rd_w_i/reg_write_w_i producer stages; forward_a_o/forward_b_o selects.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0]   rs1_e_i,
  input  logic [4:0]   rs2_e_i,
  input  logic [4:0]   rd_m_i,
  input  logic [4:0]   rd_w_i,
  input  logic         reg_write_m_i,
  input  logic         reg_write_w_i,
  output forward_sel_t forward_a_o,
  output forward_sel_t forward_b_o
);

  assign forward_a_o = fwd_select(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign forward_b_o = fwd_select(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forward sequencing for a 5-stage RV32
// pipeline, including holding Execute while a MUL (fixed latency) or DIV
// (done handshake) runs. Ports: Decode/Execute/Memory/Writeback register fields,
// MDU start/busy/done, stall_*/flush_* hooks, forward selects, perf counters.
// Optional HAZARD_PERF_CNT_EN: saturating stall-cycle and flush counters;
// without it stall_cycles_o/flush_count_o are tied to zero.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int PERF_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [4:0]        rs1_d_i,
  input  logic [4:0]        rs2_d_i,
  input  logic [4:0]        rs1_e_i,
  input  logic [4:0]        rs2_e_i,
  input  logic [4:0]        rd_e_i,
  input  logic [4:0]        rd_m_i,
  input  logic [4:0]        rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  input  logic [1:0]        result_src_e_i,
  input  logic              pc_src_e_i,
  input  logic              mdu_op_e_i,
  input  logic              mdu_is_div_e_i,
  input  logic              mdu_done_i,
  output logic [1:0]        forward_ae_o,
  output logic [1:0]        forward_be_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              flush_m_o,
  output logic              mdu_start_o,
  output logic              mdu_busy_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_count_o
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  forward_sel_t fwd_a, fwd_b;

  forwarding_unit u_fwd (
    .rs1_e_i       (rs1_e_i),
    .rs2_e_i       (rs2_e_i),
    .rd_m_i        (rd_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_m_i (reg_write_m_i),
    .reg_write_w_i (reg_write_w_i),
    .forward_a_o   (fwd_a),
    .forward_b_o   (fwd_b)
  );

  assign forward_ae_o = fwd_a;
  assign forward_be_o = fwd_b;

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_hold_q;
  logic             out_en, load_use, hold, start;

  // Control outputs stay quiet in the reset cycle and the one after it, so the
  // datapath leaving reset never sees a stray stall, flush or MDU start.
  assign out_en = rst_n_i & ~rst_hold_q;

  assign load_use = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != 5'd0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_hold_q <= 1'b0;
    end
  end

  // hold covers the start cycle and every wait cycle except the release cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        // A taken branch squashes the op in Execute, so it must not start.
        if (out_en && mdu_op_e_i && !pc_src_e_i) begin
          start = 1'b1;
          hold  = 1'b1;
          if (mdu_is_div_e_i) begin
            state_d = DIV_WAIT;
          end else begin
            state_d = MUL_WAIT;
            cnt_d   = MUL_LOAD;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_WAIT: begin
        if (mdu_done_i) state_d = IDLE;
        else            hold    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // While holding, Execute keeps the MDU op and M receives a bubble; branch and
  // load-use flushes of D/E are suppressed so the held op is not lost.
  assign stall_f_o   = out_en & (hold | load_use);
  assign stall_d_o   = out_en & (hold | load_use);
  assign stall_e_o   = out_en & hold;
  assign flush_m_o   = out_en & hold;
  assign flush_d_o   = out_en & ~hold & pc_src_e_i;
  assign flush_e_o   = out_en & ~hold & (pc_src_e_i | load_use);
  assign mdu_start_o = out_en & start;
  assign mdu_busy_o  = out_en & (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (flush_d_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule
